// File: rtl/shift_sequencer.sv
// Multi-cycle barrel shifter: one logarithmic stage (1, 2, 4, 8, 16) per clock,
// five stages per operation, with a one-cycle done/err pulse and a held result.
module shift_sequencer #(
  parameter logic [5:0] SLL = 6'b000000,
  parameter logic [5:0] SRL = 6'b000010,
  parameter logic [5:0] SRA = 6'b000011
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic [5:0]  Signal,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] dataOut
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  stage_q, stage_d;
  logic [31:0] work_q, work_d;
  logic [4:0]  amt_q, amt_d;
  logic [5:0]  op_q, op_d;
  logic [31:0] dout_q, dout_d;
  logic        err_q, err_d;

  logic [7:0]  amt_ext;
  logic [31:0] stage_val;
  logic        supported;
  logic        unused_dataB_hi;

  // One logarithmic stage: shift by 2^k with the fill chosen by the opcode.
  function automatic logic [31:0] apply_stage(input logic [31:0] val,
                                              input logic [5:0]  op,
                                              input logic [2:0]  k);
    logic [4:0] sh;
    sh = 5'd1 << k;
    case (op)
      SLL:     return val << sh;
      SRL:     return val >> sh;
      SRA:     return $unsigned($signed(val) >>> sh);
      default: return val;
    endcase
  endfunction

  assign unused_dataB_hi = ^dataB[31:5];
  assign amt_ext   = {3'b000, amt_q};
  assign supported = (op_q == SLL) || (op_q == SRL) || (op_q == SRA);
  assign stage_val = amt_ext[stage_q] ? apply_stage(work_q, op_q, stage_q) : work_q;

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    work_d  = work_q;
    amt_d   = amt_q;
    op_d    = op_q;
    dout_d  = dout_q;
    err_d   = err_q;
    case (state_q)
      IDLE, DONE: begin
        // err is only meaningful during the done cycle, so drop it on exit.
        err_d = 1'b0;
        if (start) begin
          work_d  = dataA;
          amt_d   = dataB[4:0];
          op_d    = Signal;
          stage_d = 3'd0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        work_d = stage_val;
        if (stage_q == 3'd4) begin
          dout_d  = supported ? stage_val : 32'h0;
          err_d   = ~supported;
          state_d = DONE;
        end else begin
          stage_d = stage_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      stage_q <= 3'd0;
      work_q  <= 32'h0;
      amt_q   <= 5'd0;
      op_q    <= 6'd0;
      dout_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      work_q  <= work_d;
      amt_q   <= amt_d;
      op_q    <= op_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
    end
  end

  assign busy    = (state_q == SHIFT);
  assign done    = (state_q == DONE);
  assign err     = err_q;
  assign dataOut = dout_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: a transaction-level model checked every cycle,
// plus directed operations with hand-computed results and latencies.
module tb_shift_sequencer;
  localparam logic [5:0] SLL = 6'b000000;
  localparam logic [5:0] SRL = 6'b000010;
  localparam logic [5:0] SRA = 6'b000011;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dataA = 32'h0;
  logic [31:0] dataB = 32'h0;
  logic [5:0]  Signal = 6'h0;
  logic        busy, done, err;
  logic [31:0] dataOut;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  shift_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .dataA(dataA), .dataB(dataB),
    .Signal(Signal), .busy(busy), .done(done), .err(err), .dataOut(dataOut)
  );

  // Transaction model: an accepted op completes 5 edges later with a direct shift.
  logic        m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0, p_err = 1'b0;
  logic [31:0] m_dout = 32'h0, p_res = 32'h0;
  int          m_cnt = 0;

  task automatic model_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic e);
    logic signed [31:0] sa;
    int n;
    n  = int'(b[4:0]);
    sa = a;
    e  = 1'b0;
    case (op)
      SLL:     r = a << n;
      SRL:     r = a >> n;
      SRA:     r = sa >>> n;
      default: begin r = 32'h0; e = 1'b1; end
    endcase
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_dout = 32'h0; m_cnt = 0;
    end else begin
      m_done = 1'b0;
      m_err  = 1'b0;
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 1'b0; m_done = 1'b1; m_dout = p_res; m_err = p_err;
        end
      end else if (start) begin
        model_op(Signal, dataA, dataB, p_res, p_err);
        m_busy = 1'b1;
        m_cnt  = 5;
      end
    end
  end

  always begin
    @(posedge clk);
    #2;
    n_chk++;
    if ({busy, done, err, dataOut} !== {m_busy, m_done, m_err, m_dout}) begin
      n_fail++;
      $display("FAIL cycle_model t=%0t act busy=%b done=%b err=%b out=%h req busy=%b done=%b err=%b out=%h",
               $time, busy, done, err, dataOut, m_busy, m_done, m_err, m_dout);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s act=%h req=%h", name, act, req);
    end
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    Signal = op; dataA = a; dataB = b; start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    dataA  = $urandom;
    dataB  = $urandom;
    Signal = 6'($urandom);
  endtask

  // k0 = index of the last edge already passed, counting the capture edge as 0.
  task automatic wait_done(input string name, input logic [31:0] req, input logic req_err, input int k0);
    int  k;
    bit  got;
    k   = k0;
    got = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #3;
      k++;
      if (done) begin got = 1'b1; break; end
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout act=no_done req=done_at_edge_5", name);
    end else begin
      check({name, "_lat"}, 32'(k), 32'd5);
      check({name, "_out"}, dataOut, req);
      check({name, "_err"}, {31'h0, err}, {31'h0, req_err});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones, d1_k, d2_k;
    logic [31:0] d1_out, d2_out;

    #1 reset = 1'b1;
    @(negedge clk);
    start = 1'b1; Signal = SLL; dataA = 32'h1; dataB = 32'h1;
    check("rst_ctl", {29'h0, busy, done, err}, 32'h0);
    check("rst_out", dataOut, 32'h0);
    @(negedge clk);
    reset = 1'b0; start = 1'b0;

    issue(SRL, 32'h80000000, 32'd31);
    wait_done("srl31", 32'h00000001, 1'b0, 0);
    issue(SRA, 32'h80000000, 32'd4);
    wait_done("sra4", 32'hF8000000, 1'b0, 0);
    issue(SLL, 32'h00000001, 32'd31);
    wait_done("sll31", 32'h80000000, 1'b0, 0);

    // Re-pulsed start at E2 must be ignored.
    issue(SRL, 32'h12345678, 32'h00000021);
    @(negedge clk);
    start = 1'b1; Signal = SLL; dataA = 32'hFFFFFFFF; dataB = 32'd7;
    @(negedge clk);
    start = 1'b0;
    check("busy_e2", {31'h0, busy}, 32'h1);
    wait_done("repulse", 32'h091A2B3C, 1'b0, 2);

    issue(6'b100000, 32'hFFFFFFFF, 32'd5);
    wait_done("badop", 32'h00000000, 1'b1, 0);
    issue(SLL, 32'h00000003, 32'd2);
    wait_done("after_bad", 32'h0000000C, 1'b0, 0);
    issue(SRA, 32'h80001234, 32'hFFFFFFE0);
    wait_done("amt0", 32'h80001234, 1'b0, 0);

    // Reset between E2 and E3 of an SLL.
    issue(SLL, 32'h000000FF, 32'd3);
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("midrst_ctl", {29'h0, busy, done, err}, 32'h0);
    check("midrst_out", dataOut, 32'h0);
    #1 reset = 1'b0;
    dones = 0;
    repeat (8) begin
      @(posedge clk);
      #3;
      if (done) dones++;
    end
    check("midrst_nodone", 32'(dones), 32'd0);
    issue(SRL, 32'hF0000000, 32'd28);
    wait_done("after_rst", 32'h0000000F, 1'b0, 0);

    // start held high with two operations queued.
    @(negedge clk);
    Signal = SLL; dataA = 32'h1; dataB = 32'd5; start = 1'b1;
    @(negedge clk);
    Signal = SRA; dataA = 32'h80000000; dataB = 32'd1;
    d1_k = -1; d2_k = -1; d1_out = 32'h0; d2_out = 32'h0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk);
      #3;
      if (done) begin
        if (d1_k < 0) begin d1_k = k; d1_out = dataOut; end
        else begin d2_k = k; d2_out = dataOut; end
      end
      if (k == 6) begin
        @(negedge clk);
        start = 1'b0;
      end
    end
    check("b2b_first_k", 32'(d1_k), 32'd5);
    check("b2b_first_out", d1_out, 32'h00000020);
    check("b2b_second_k", 32'(d2_k), 32'd11);
    check("b2b_second_out", d2_out, 32'hC0000000);

    repeat (3) @(posedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
